// File: rtl/tt_vpu_ovi_store_packer.sv
// OVI store packer: buffers vs3 registers, emits OVI_DW beats of OVI_DW/VLEN registers at N+2 (N+1 via TT_VPU_OVI_STORE_BYPASS_EN),
// metered by store credits; o_st_reg_ready drops when the buffer is full, beats and data hold while credits are zero.
module tt_vpu_ovi_store_packer #(
    parameter int VLEN          = 256,
    parameter int OVI_DW        = 512,
    parameter int DEPTH         = 8,
    parameter int STORE_CREDITS = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_st_start,
    input  logic              i_st_reg_valid,
    input  logic [VLEN-1:0]   i_st_reg_data,
    input  logic              i_st_last,
    output logic              o_st_reg_ready,
    input  logic              i_kill,
    output logic              store_valid,
    output logic [OVI_DW-1:0] store_data,
    input  logic              store_credit,
    output logic              memop_sync_start,
    input  logic              memop_sync_end,
    input  logic              i_lq_empty,
    output logic              o_store_commit,
    output logic              o_busy
);
    localparam int RPB = OVI_DW / VLEN;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CRW = $clog2(STORE_CREDITS) + 1;
    localparam logic [CW-1:0]  RPB_C    = CW'(RPB);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [CRW-1:0] CRED_MAX = CRW'(STORE_CREDITS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        DRAIN   = 3'd2,
        SYNC    = 3'd3,
        WAIT_LQ = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [VLEN-1:0]    mem_q [DEPTH];
    logic [PW-1:0]      wptr_q, rptr_q;
    logic [CW-1:0]      count_q;
    logic [CRW-1:0]     credits_q;
    logic               store_valid_q;
    logic [OVI_DW-1:0]  store_data_q;
    logic               sync_start_q;
    logic               sync_seen_q, sync_seen_d;
    logic               commit_q;
    logic               busy_q;

    logic               push, push_wr, credit_ok, in_pack;
    logic               pop_full, pop_part, bypass, issue;
    logic [CW-1:0]      pop_n;
    logic [OVI_DW-1:0]  beat_dat;

    always_comb begin
        push      = i_st_reg_valid && o_st_reg_ready;
        credit_ok = (credits_q != '0);
        in_pack   = (state_q == FILL) || (state_q == DRAIN);
        pop_full  = in_pack && credit_ok && (count_q >= RPB_C);
        pop_part  = (state_q == DRAIN) && credit_ok && (count_q != '0) && (count_q < RPB_C);
        pop_n     = pop_full ? RPB_C : (pop_part ? count_q : '0);
    end

`ifdef TT_VPU_OVI_STORE_BYPASS_EN
    // Set on start, cleared by the first accepted register of the store.
    logic first_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            first_q <= 1'b0;
        end else if (i_kill) begin
            first_q <= 1'b0;
        end else if ((state_q == IDLE) && i_st_start) begin
            first_q <= 1'b1;
        end else if (push) begin
            first_q <= 1'b0;
        end
    end

    assign bypass = push && i_st_last && first_q && (count_q == '0) && credit_ok;
`else
    assign bypass = 1'b0;
`endif

    assign push_wr = push && !bypass;
    assign issue   = bypass || pop_full || pop_part;

    // Lanes above the popped count stay zero, which pads the final partial beat.
    always_comb begin
        beat_dat = '0;
        if (bypass) begin
            beat_dat[VLEN-1:0] = i_st_reg_data;
        end else begin
            for (int k = 0; k < RPB; k++) begin
                if (CW'(k) < pop_n) begin
                    beat_dat[k*VLEN +: VLEN] = mem_q[rptr_q + PW'(k)];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_st_start) state_d = FILL;
            FILL:    if (push && i_st_last) state_d = DRAIN;
            DRAIN:   if ((count_q == '0) && !store_valid_q) state_d = SYNC;
            SYNC:    if (sync_seen_q || (memop_sync_end && !sync_start_q)) state_d = WAIT_LQ;
            WAIT_LQ: if (i_lq_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_kill) state_d = IDLE;
    end

    // Sync end may arrive any time after the start pulse; hold it until the store retires.
    always_comb begin
        sync_seen_d = sync_seen_q;
        if (state_d == IDLE) begin
            sync_seen_d = 1'b0;
        end else if ((state_q != IDLE) && !sync_start_q && memop_sync_end) begin
            sync_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_wr) begin
            mem_q[wptr_q] <= i_st_reg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            credits_q     <= CRED_MAX;
            store_valid_q <= 1'b0;
            store_data_q  <= '0;
            sync_start_q  <= 1'b0;
            sync_seen_q   <= 1'b0;
            commit_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_seen_q   <= sync_seen_d;
            busy_q        <= (state_d != IDLE);
            sync_start_q  <= (state_q == IDLE) && i_st_start && !i_kill;
            commit_q      <= (state_q == WAIT_LQ) && i_lq_empty && !i_kill;
            store_valid_q <= issue;
            if (issue) begin
                store_data_q <= beat_dat;
            end

            if (i_kill) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (push_wr) begin
                    wptr_q <= wptr_q + PW'(1);
                end
                rptr_q  <= rptr_q + pop_n[PW-1:0];
                count_q <= count_q + CW'(push_wr) - pop_n;
            end

            case ({issue, store_credit})
                2'b10:   credits_q <= credits_q - CRW'(1);
                2'b01:   if (credits_q < CRED_MAX) credits_q <= credits_q + CRW'(1);
                default: credits_q <= credits_q;
            endcase
        end
    end

    assign o_st_reg_ready   = (state_q == FILL) && (count_q < DEPTH_C);
    assign store_valid      = store_valid_q;
    assign store_data       = store_data_q;
    assign memop_sync_start = sync_start_q;
    assign o_store_commit   = commit_q;
    assign o_busy           = busy_q;

endmodule

// File: tb/tb_tt_vpu_ovi_store_packer.sv
// Directed bench for the OVI store packer with default parameters (VLEN=256, OVI_DW=512, DEPTH=8, 32 credits).
module tb_tt_vpu_ovi_store_packer;
    localparam int VLEN   = 256;
    localparam int OVI_DW = 512;

    logic              clk;
    logic              reset_n;
    logic              i_st_start;
    logic              i_st_reg_valid;
    logic [VLEN-1:0]   i_st_reg_data;
    logic              i_st_last;
    logic              o_st_reg_ready;
    logic              i_kill;
    logic              store_valid;
    logic [OVI_DW-1:0] store_data;
    logic              store_credit;
    logic              memop_sync_start;
    logic              memop_sync_end;
    logic              i_lq_empty;
    logic              o_store_commit;
    logic              o_busy;

    tt_vpu_ovi_store_packer #(
        .VLEN(VLEN), .OVI_DW(OVI_DW), .DEPTH(8), .STORE_CREDITS(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_st_start(i_st_start),
        .i_st_reg_valid(i_st_reg_valid), .i_st_reg_data(i_st_reg_data),
        .i_st_last(i_st_last), .o_st_reg_ready(o_st_reg_ready), .i_kill(i_kill),
        .store_valid(store_valid), .store_data(store_data), .store_credit(store_credit),
        .memop_sync_start(memop_sync_start), .memop_sync_end(memop_sync_end),
        .i_lq_empty(i_lq_empty), .o_store_commit(o_store_commit), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [OVI_DW-1:0] bq_dat[$];
    int                bq_cyc[$];
    int                n_commit = 0;
    int                last_commit_cyc = -1;

    always @(negedge clk) begin
        if (store_valid) begin
            bq_dat.push_back(store_data);
            bq_cyc.push_back(cyc);
        end
        if (o_store_commit) begin
            n_commit        <= n_commit + 1;
            last_commit_cyc <= cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [OVI_DW-1:0] obs, input logic [OVI_DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VLEN-1:0] mk(input int tag, input int idx);
        mk = {8{tag[15:0], idx[15:0]}};
    endfunction

    function automatic logic [OVI_DW-1:0] bt(input logic [VLEN-1:0] hi, input logic [VLEN-1:0] lo);
        bt = {hi, lo};
    endfunction

    task automatic start_store(input string tag);
        i_st_start = 1'b1;
        tick();
        i_st_start = 1'b0;
        chk({tag, "_sync_start"}, memop_sync_start, 1);
        chk({tag, "_busy"}, o_busy, 1);
        tick();
        chk({tag, "_sync_start_pulse"}, memop_sync_start, 0);
    endtask

    task automatic push_reg(input logic [VLEN-1:0] d, input logic last, output int acc);
        int g;
        g = 0;
        i_st_reg_valid = 1'b1;
        i_st_reg_data  = d;
        i_st_last      = last;
        while (!o_st_reg_ready && g < 200) begin
            tick();
            g++;
        end
        if (g >= 200) begin
            checks++;
            errors++;
            $error("FAIL push_timeout: ready never seen, waited %0d cycles", g);
        end
        acc = cyc + 1;
        tick();
        i_st_reg_valid = 1'b0;
        i_st_last      = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int g;
        g = 0;
        while (bq_dat.size() < target && g < budget) begin
            tick();
            g++;
        end
        chk(tag, bq_dat.size(), target);
    endtask

    task automatic credits(input int n);
        for (int i = 0; i < n; i++) begin
            store_credit = 1'b1;
            tick();
        end
        store_credit = 1'b0;
    endtask

    task automatic do_commit(input string tag);
        int c0, e;
        c0 = n_commit;
        repeat (6) tick();
        memop_sync_end = 1'b1;
        e = cyc + 1;
        tick();
        memop_sync_end = 1'b0;
        repeat (4) tick();
        chk({tag, "_commit_cnt"}, n_commit, c0 + 1);
        chk({tag, "_commit_cyc"}, last_commit_cyc, e + 1);
        chk({tag, "_idle"}, o_busy, 0);
    endtask

    initial begin
        int a[70];
        int b0, k, d, nb, c0, lq, exp_lat;

        reset_n = 1'b0; i_st_start = 1'b0; i_st_reg_valid = 1'b0; i_st_reg_data = '0;
        i_st_last = 1'b0; i_kill = 1'b0; store_credit = 1'b0; memop_sync_end = 1'b0;
        i_lq_empty = 1'b1;
        repeat (3) tick();
        chk("rst_valid", store_valid, 0);
        chk("rst_data", store_data, 0);
        chk("rst_sync_start", memop_sync_start, 0);
        chk("rst_commit", o_store_commit, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", o_st_reg_ready, 0);
        reset_n = 1'b1;
        tick();

        // 4-register store: two full beats, credits 32 -> 30
        b0 = bq_dat.size();
        start_store("t1");
        for (int i = 0; i < 4; i++) push_reg(mk(1, i), i == 3, a[i]);
        wait_beats("t1_beats", b0 + 2, 20);
        chk("t1_beat0", bq_dat[b0], bt(mk(1, 1), mk(1, 0)));
        chk("t1_beat0_cyc", bq_cyc[b0], a[1] + 1);
        chk("t1_beat1", bq_dat[b0 + 1], bt(mk(1, 3), mk(1, 2)));
        chk("t1_beat1_cyc", bq_cyc[b0 + 1], a[3] + 1);
        do_commit("t1");

        // 3-register store, sync end during FILL, load queue busy: credits 30 -> 28
        b0 = bq_dat.size();
        c0 = n_commit;
        i_lq_empty = 1'b0;
        start_store("t2");
        push_reg(mk(2, 0), 1'b0, a[0]);
        memop_sync_end = 1'b1;
        push_reg(mk(2, 1), 1'b0, a[1]);
        memop_sync_end = 1'b0;
        push_reg(mk(2, 2), 1'b1, a[2]);
        wait_beats("t2_beats", b0 + 2, 20);
        chk("t2_beat0", bq_dat[b0], bt(mk(2, 1), mk(2, 0)));
        chk("t2_beat1_pad", bq_dat[b0 + 1], bt('0, mk(2, 2)));
        chk("t2_beat1_cyc", bq_cyc[b0 + 1], a[2] + 1);
        repeat (8) tick();
        chk("t2_no_commit_lq_busy", n_commit, c0);
        chk("t2_busy_wait_lq", o_busy, 1);
        i_lq_empty = 1'b1;
        lq = cyc + 1;
        repeat (3) tick();
        chk("t2_commit_cnt", n_commit, c0 + 1);
        chk("t2_commit_cyc", last_commit_cyc, lq);
        // 5 returns against 4 used: saturates at 32
        credits(5);

        // 62-register store uses 31 credits, leaving exactly 1
        b0 = bq_dat.size();
        start_store("t3");
        for (int i = 0; i < 62; i++) push_reg(mk(3, i), i == 61, a[0]);
        wait_beats("t3_beats", b0 + 31, 40);
        for (int j = 0; j < 31; j++)
            chk($sformatf("t3_beat%0d", j), bq_dat[b0 + j], bt(mk(3, 2 * j + 1), mk(3, 2 * j)));
        do_commit("t3");

        // one credit left: one beat, stall with data held, resume one credit later
        b0 = bq_dat.size();
        start_store("t4");
        for (int i = 0; i < 4; i++) push_reg(mk(4, i), i == 3, a[i]);
        wait_beats("t4_first", b0 + 1, 20);
        chk("t4_beat0", bq_dat[b0], bt(mk(4, 1), mk(4, 0)));
        repeat (6) tick();
        chk("t4_stall_cnt", bq_dat.size(), b0 + 1);
        chk("t4_stall_valid", store_valid, 0);
        chk("t4_stall_hold", store_data, bt(mk(4, 1), mk(4, 0)));
        k = cyc;
        credits(1);
        wait_beats("t4_second", b0 + 2, 10);
        chk("t4_beat1", bq_dat[b0 + 1], bt(mk(4, 3), mk(4, 2)));
        chk("t4_beat1_cyc", bq_cyc[b0 + 1], k + 2);
        do_commit("t4");

        // 12-register store with zero credits: buffer fills at 8, then wraps
        b0 = bq_dat.size();
        start_store("t5");
        for (int i = 0; i < 8; i++) push_reg(mk(5, i), 1'b0, a[i]);
        chk("t5_full_ready", o_st_reg_ready, 0);
        repeat (3) tick();
        chk("t5_full_ready_hold", o_st_reg_ready, 0);
        chk("t5_no_beats", bq_dat.size(), b0);
        d = cyc;
        credits(6);
        for (int i = 8; i < 12; i++) push_reg(mk(5, i), i == 11, a[i]);
        wait_beats("t5_beats", b0 + 6, 40);
        chk("t5_beat0_cyc", bq_cyc[b0], d + 2);
        for (int j = 0; j < 6; j++)
            chk($sformatf("t5_beat%0d", j), bq_dat[b0 + j], bt(mk(5, 2 * j + 1), mk(5, 2 * j)));
        do_commit("t5");

        // kill in DRAIN with 2 entries pending and a latched sync end
        c0 = n_commit;
        start_store("t6");
        push_reg(mk(6, 0), 1'b0, a[0]);
        push_reg(mk(6, 1), 1'b1, a[1]);
        memop_sync_end = 1'b1;
        tick();
        memop_sync_end = 1'b0;
        tick();
        nb = bq_dat.size();
        i_kill = 1'b1;
        tick();
        i_kill = 1'b0;
        chk("t6_busy", o_busy, 0);
        chk("t6_ready", o_st_reg_ready, 0);
        credits(3);
        repeat (8) tick();
        chk("t6_no_beats", bq_dat.size(), nb);
        chk("t6_no_commit", n_commit, c0);

        // single-register store after kill
`ifdef TT_VPU_OVI_STORE_BYPASS_EN
        exp_lat = 0;
`else
        exp_lat = 1;
`endif
        b0 = bq_dat.size();
        c0 = n_commit;
        start_store("t7");
        push_reg(mk(7, 0), 1'b1, a[0]);
        wait_beats("t7_beats", b0 + 1, 10);
        chk("t7_beat", bq_dat[b0], bt('0, mk(7, 0)));
        chk("t7_beat_cyc", bq_cyc[b0], a[0] + exp_lat);
        repeat (6) tick();
        chk("t7_stale_sync", n_commit, c0);
        do_commit("t7");

        // reset mid-store restores 32 credits
        start_store("t8");
        for (int i = 0; i < 3; i++) push_reg(mk(8, i), 1'b0, a[i]);
        reset_n = 1'b0;
        repeat (2) tick();
        chk("t8_rst_valid", store_valid, 0);
        chk("t8_rst_data", store_data, 0);
        chk("t8_rst_busy", o_busy, 0);
        chk("t8_rst_ready", o_st_reg_ready, 0);
        chk("t8_rst_commit", o_store_commit, 0);
        reset_n = 1'b1;
        tick();
        b0 = bq_dat.size();
        start_store("t9");
        for (int i = 0; i < 66; i++) push_reg(mk(9, i), i == 65, a[0]);
        wait_beats("t9_beats", b0 + 32, 60);
        repeat (10) tick();
        chk("t9_credit_limit", bq_dat.size(), b0 + 32);
        chk("t9_last_beat", bq_dat[b0 + 31], bt(mk(9, 63), mk(9, 62)));
        i_kill = 1'b1;
        tick();
        i_kill = 1'b0;
        chk("t9_kill_idle", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
